muldiv_iter_unit: RTL and testbench

- Parametrised, multi-cycle RV32M/RV64M multiply/divide unit with a valid/ready handshake.
- Replaces the single-cycle combinational MUL/DIV paths in the execute stage. The CPU stalls on In_Ready/Out_Valid instead of carrying a long combinational divider path.
- Radix-2 iterative core: one shift-add or shift-subtract per cycle on operand magnitudes, followed by a sign-fix cycle.

---
 rtl/muldiv_iter_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_muldiv_iter_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter_unit.sv
// Iterative radix-2 RV32M/RV64M multiply/divide unit with valid/ready handshake.
// Each CALC cycle does one shift-add (multiply) or one restoring shift-subtract
// (divide) on operand magnitudes; a FIX cycle then applies the result signs.
// Optional feature macro: MULDIV_FAST_MUL_EN. When defined, multiplies use a
// combinational multiplier and finish one cycle after acceptance.
module muldiv_iter_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Flush,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [XLEN-1:0]  Src1,
  input  logic [XLEN-1:0]  Src2,
  input  logic [2:0]       MulDiv_op,
  input  logic [TAG_W-1:0] In_Tag,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [XLEN-1:0]  Result,
  output logic [TAG_W-1:0] Out_Tag,
  output logic             Busy
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned ACC_W = 2 * XLEN;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic [2:0]         op_q, op_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]    mcand_q, mcand_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]    result_q, result_d;

  logic               accept;
  logic               src1_signed, src2_signed;
  logic               neg_a, neg_b;
  logic [XLEN-1:0]    mag_a, mag_b;
  logic               div_zero, div_ovf, special;
  logic [XLEN-1:0]    special_res;

  logic [XLEN:0]      mul_sum;
  logic [XLEN:0]      div_shift, div_trial;
  logic [ACC_W-1:0]   fix_prod;
  logic [XLEN-1:0]    fix_quo, fix_rem;

`ifdef MULDIV_FAST_MUL_EN
  logic [ACC_W-1:0]   ext_a, ext_b, fast_prod;
`endif

  assign accept = (state_q == S_IDLE) && In_Valid && !Flush;

  // Request decode: operand signedness, magnitudes and single-cycle cases
  always_comb begin
    src1_signed = (MulDiv_op == OP_MUL) || (MulDiv_op == OP_MULH) ||
                  (MulDiv_op == OP_MULHSU) || (MulDiv_op == OP_DIV) ||
                  (MulDiv_op == OP_REM);
    src2_signed = (MulDiv_op == OP_MUL) || (MulDiv_op == OP_MULH) ||
                  (MulDiv_op == OP_DIV) || (MulDiv_op == OP_REM);
    neg_a    = src1_signed && Src1[XLEN-1];
    neg_b    = src2_signed && Src2[XLEN-1];
    mag_a    = neg_a ? -Src1 : Src1;
    mag_b    = neg_b ? -Src2 : Src2;
    div_zero = MulDiv_op[2] && (Src2 == '0);
    div_ovf  = ((MulDiv_op == OP_DIV) || (MulDiv_op == OP_REM)) &&
               (Src1 == XMIN) && (Src2 == '1);
    special     = div_zero || div_ovf;
    special_res = '0;
    if (div_zero) begin
      special_res = MulDiv_op[1] ? Src1 : '1;
    end else if (div_ovf) begin
      special_res = MulDiv_op[1] ? '0 : Src1;
    end
`ifdef MULDIV_FAST_MUL_EN
    ext_a     = {{XLEN{neg_a}}, Src1};
    ext_b     = {{XLEN{neg_b}}, Src2};
    fast_prod = ext_a * ext_b;
    if (!MulDiv_op[2]) begin
      special     = 1'b1;
      special_res = (MulDiv_op == OP_MUL) ? fast_prod[XLEN-1:0]
                                          : fast_prod[ACC_W-1:XLEN];
    end
`endif
  end

  // Iteration step and sign-fix arithmetic
  always_comb begin
    mul_sum   = {1'b0, acc_q[ACC_W-1:XLEN]} +
                ({1'b0, mcand_q} & {(XLEN+1){acc_q[0]}});
    div_shift = {acc_q[ACC_W-1:XLEN], acc_q[XLEN-1]};
    div_trial = div_shift - {1'b0, mcand_q};
    fix_prod  = neg_q ? -acc_q : acc_q;
    fix_quo   = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    fix_rem   = neg_rem_q ? -acc_q[ACC_W-1:XLEN] : acc_q[ACC_W-1:XLEN];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; Flush wins over In_Valid and Out_Ready
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = special ? S_DONE : S_CALC;
      S_CALC: begin
        if (Flush) state_d = S_IDLE;
        else if (cnt_q == CNT_W'(XLEN - 1)) state_d = S_FIX;
      end
      S_FIX:  state_d = Flush ? S_IDLE : S_DONE;
      S_DONE: if (Flush || Out_Ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
    op_d        = op_q;
    out_tag_d   = out_tag_q;
    neg_d       = neg_q;
    neg_rem_d   = neg_rem_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d      = MulDiv_op;
          out_tag_d = In_Tag;
          cnt_d     = '0;
          neg_d     = neg_a ^ neg_b;
          neg_rem_d = neg_a;
          if (MulDiv_op[2]) begin
            mcand_d = mag_b;
            acc_d   = {{XLEN{1'b0}}, mag_a};
          end else begin
            mcand_d = mag_a;
            acc_d   = {{XLEN{1'b0}}, mag_b};
          end
          if (special) result_d = special_res;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_q[2]) begin
          // Restoring divide: remainder in the upper half, quotient shifts into the lower half
          if (!div_trial[XLEN]) begin
            acc_d = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          end else begin
            acc_d = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
          end
        end else begin
          // Shift-add multiply: multiplier shifts out of the lower half
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
      end
      S_FIX: begin
        case (op_q)
          OP_MUL:                      result_d = fix_prod[XLEN-1:0];
          OP_MULH, OP_MULHSU, OP_MULHU: result_d = fix_prod[ACC_W-1:XLEN];
          OP_DIV, OP_DIVU:             result_d = fix_quo;
          default:                     result_d = fix_rem;
        endcase
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      op_q        <= '0;
      out_tag_q   <= '0;
      neg_q       <= 1'b0;
      neg_rem_q   <= 1'b0;
      mcand_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      op_q        <= op_d;
      out_tag_q   <= out_tag_d;
      neg_q       <= neg_d;
      neg_rem_q   <= neg_rem_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
    end
  end

  assign In_Ready  = in_ready_q;
  assign Out_Valid = out_valid_q;
  assign Busy      = busy_q;
  assign Result    = result_q;
  assign Out_Tag   = out_tag_q;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Self-checking bench for muldiv_iter_unit (XLEN=32) with a behavioural model.
module tb_muldiv_iter_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 5;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic             clk, rst_n, Flush, In_Valid, In_Ready, Out_Valid, Out_Ready, Busy;
  logic [XLEN-1:0]  Src1, Src2, Result;
  logic [2:0]       MulDiv_op;
  logic [TAG_W-1:0] In_Tag, Out_Tag;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_iter_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .Flush(Flush), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Src1(Src1), .Src2(Src2), .MulDiv_op(MulDiv_op), .In_Tag(In_Tag),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Result(Result), .Out_Tag(Out_Tag),
    .Busy(Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference result from plain 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint as_, bs, au, bu, r;
    as_ = longint'($signed(a));
    bs  = longint'($signed(b));
    au  = longint'({32'h0, a});
    bu  = longint'({32'h0, b});
    r   = 0;
    case (op)
      3'd0: begin r = as_ * bs; return r[31:0];  end
      3'd1: begin r = as_ * bs; return r[63:32]; end
      3'd2: begin r = as_ * bu; return r[63:32]; end
      3'd3: begin r = au * bu;  return r[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        r = as_ / bs; return r[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        r = au / bu; return r[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        r = as_ % bs; return r[31:0];
      end
      default: begin
        if (b == 0) return a;
        r = au % bu; return r[31:0];
      end
    endcase
  endfunction

  // Cycles from acceptance edge to first Out_Valid
  function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    if (!op[2] && FAST) return 1;
    return XLEN + 2;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one request, wait for its result, optionally stall the consumer, then retire it
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input int hold, input logic [31:0] exp_r);
    int tries;
    int lat;
    bit seen;
    @(negedge clk);
    tries = 0;
    while (!In_Ready && tries < 100) begin
      @(negedge clk);
      tries++;
    end
    if (!In_Ready) begin
      check_eq("ready_timeout", 64'(In_Ready), 64'd1);
      return;
    end
    In_Valid  = 1'b1;
    MulDiv_op = op;
    Src1      = a;
    Src2      = b;
    In_Tag    = tag;
    @(posedge clk);
    #1;
    In_Valid = 1'b0;
    Src1     = $urandom;
    Src2     = $urandom;
    In_Tag   = 5'($urandom);
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 200 && !seen; i++) begin
      @(negedge clk);
      if (Out_Valid) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    check_eq("latency", 64'(lat), 64'(lat_of(op, a, b)));
    if (!seen) return;
    check_eq("result", 64'(Result), 64'(exp_r));
    check_eq("out_tag", 64'(Out_Tag), 64'(tag));
    check_eq("in_ready_done", 64'(In_Ready), 64'd0);
    check_eq("busy_done", 64'(Busy), 64'd1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("hold_valid", 64'(Out_Valid), 64'd1);
      check_eq("hold_result", 64'(Result), 64'(exp_r));
      check_eq("hold_tag", 64'(Out_Tag), 64'(tag));
      check_eq("hold_in_ready", 64'(In_Ready), 64'd0);
    end
    Out_Ready = 1'b1;
    @(posedge clk);
    #1;
    Out_Ready = 1'b0;
    @(negedge clk);
    check_eq("valid_drop", 64'(Out_Valid), 64'd0);
    check_eq("ready_back", 64'(In_Ready), 64'd1);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    bit got_valid;

    rst_n = 1'b0; Flush = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b0;
    Src1 = '0; Src2 = '0; MulDiv_op = '0; In_Tag = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", 64'(In_Ready), 64'd1);
    check_eq("rst_out_valid", 64'(Out_Valid), 64'd0);
    check_eq("rst_result", 64'(Result), 64'd0);
    check_eq("rst_out_tag", 64'(Out_Tag), 64'd0);
    check_eq("rst_busy", 64'(Busy), 64'd0);
    rst_n = 1'b1;

    // Directed cases with hand-derived results
    run_op(3'd5, 32'd100, 32'd7, 5'd3, 0, 32'd14);
    run_op(3'd7, 32'd100, 32'd7, 5'd4, 0, 32'd2);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 0, 32'hFFFF_FFFD);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 0, 32'hFFFF_FFFF);
    run_op(3'd4, 32'h1234, 32'd0, 5'd7, 0, 32'hFFFF_FFFF);
    run_op(3'd7, 32'h1234, 32'd0, 5'd8, 0, 32'h1234);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 0, 32'h8000_0000);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0, 32'h0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd11, 0, 32'h4000_0000);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 0, 32'hFFFF_FFFF);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 0, 32'hFFFF_FFFE);
    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 0, 32'h0000_0001);
    run_op(3'd0, 32'd6, 32'hFFFF_FFFD, 5'd15, 0, 32'hFFFF_FFEE);
    run_op(3'd5, 32'd1000, 32'd33, 5'd16, 5, 32'd30);

    // Flush in IDLE blocks acceptance
    @(negedge clk);
    In_Valid = 1'b1; Flush = 1'b1; MulDiv_op = 3'd5; Src1 = 32'd9; Src2 = 32'd2;
    @(posedge clk);
    #1;
    In_Valid = 1'b0; Flush = 1'b0;
    @(negedge clk);
    check_eq("idle_flush_busy", 64'(Busy), 64'd0);
    check_eq("idle_flush_ready", 64'(In_Ready), 64'd1);

    // Flush while the counter is at 10
    In_Valid = 1'b1; MulDiv_op = 3'd5; Src1 = 32'd5000; Src2 = 32'd3; In_Tag = 5'd20;
    @(posedge clk);
    #1;
    In_Valid = 1'b0;
    repeat (11) @(negedge clk);
    check_eq("calc_busy", 64'(Busy), 64'd1);
    Flush = 1'b1;
    @(posedge clk);
    #1;
    Flush = 1'b0;
    @(negedge clk);
    check_eq("flush_busy", 64'(Busy), 64'd0);
    check_eq("flush_valid", 64'(Out_Valid), 64'd0);
    check_eq("flush_ready", 64'(In_Ready), 64'd1);
    got_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (Out_Valid) got_valid = 1'b1;
    end
    check_eq("flush_no_result", 64'(got_valid), 64'd0);
    run_op(3'd5, 32'd5000, 32'd3, 5'd21, 0, 32'd1666);

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    In_Valid = 1'b1; MulDiv_op = 3'd4; Src1 = 32'hFFFF_0000; Src2 = 32'd7; In_Tag = 5'd22;
    @(posedge clk);
    #1;
    In_Valid = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_in_ready", 64'(In_Ready), 64'd1);
    check_eq("arst_out_valid", 64'(Out_Valid), 64'd0);
    check_eq("arst_result", 64'(Result), 64'd0);
    check_eq("arst_out_tag", 64'(Out_Tag), 64'd0);
    check_eq("arst_busy", 64'(Busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd4, 32'hFFFF_0000, 32'd7, 5'd23, 0, model(3'd4, 32'hFFFF_0000, 32'd7));

    // Randomized operations against the model
    for (int n = 0; n < 48; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      run_op(op, a, b, 5'($urandom), int'($urandom_range(0, 2)), model(op, a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
